sha256_sig_cfu: RTL and testbench

SHA256_SIG_CFU -- requirements
Module: sha256_sig_cfu

---
 rtl/sha256_cfu_pkg.sv | 24 ++
 rtl/cfu_interface.sv | 26 ++
 rtl/cfu_resp_fifo.sv | 55 +++++
 rtl/sha256_sig_cfu.sv | 64 ++++++
 tb/tb_sha256_sig_cfu.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sha256_cfu_pkg.sv
// Shared types for the SHA-256 sigma/sum custom function unit: function codes,
// response status codes and the response-entry layout.
package sha256_cfu_pkg;

  localparam int CFU_ID_W   = 4;
  localparam int CFU_FUNC_W = 3;

  typedef enum logic [1:0] {
    SIG0 = 2'd0,
    SIG1 = 2'd1,
    SUM0 = 2'd2,
    SUM1 = 2'd3
  } cfu_func_e;

  localparam logic STATUS_OK      = 1'b0;
  localparam logic STATUS_ILLEGAL = 1'b1;

  typedef struct packed {
    logic [CFU_ID_W-1:0] id;
    logic                status;
    logic [31:0]         data;
  } cfu_resp_t;

endpackage

// File: rtl/cfu_interface.sv
// Request/response handshake bundle between a CPU core and a custom function unit.
interface cfu_interface #(
  parameter int ID_W   = sha256_cfu_pkg::CFU_ID_W,
  parameter int FUNC_W = sha256_cfu_pkg::CFU_FUNC_W
);
  logic              req_valid;
  logic              req_ready;
  logic [ID_W-1:0]   req_id;
  logic [FUNC_W-1:0] req_func;
  logic [31:0]       req_rs1;
  logic              resp_valid;
  logic              resp_ready;
  logic [ID_W-1:0]   resp_id;
  logic              resp_status;
  logic [31:0]       resp_data;

  modport slave (
    input  req_valid, req_id, req_func, req_rs1, resp_ready,
    output req_ready, resp_valid, resp_id, resp_status, resp_data
  );

  modport master (
    output req_valid, req_id, req_func, req_rs1, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_status, resp_data
  );
endinterface

// File: rtl/cfu_resp_fifo.sv
// In-order response buffer: DEPTH entries of WIDTH bits, one push and one pop
// per cycle; head is forced to zero while empty so outputs read 0 after reset.
module cfu_resp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 37
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [WIDTH-1:0] push_data,
  output logic             pop_valid,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] pop_data
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push, pop, not_empty;

  assign not_empty  = (count_q != '0);
  assign push_ready = (count_q != CNT_W'(DEPTH));
  assign pop_valid  = not_empty;
  assign pop_data   = not_empty ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    push     = push_valid & push_ready;
    pop      = not_empty & pop_ready;
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity comes solely from count_q.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/sha256_sig_cfu.sv
// SHA-256 sigma0/sigma1/Sum0/Sum1 custom function unit with buffered in-order responses.
// Build option: define SHA256_SIG_CFU_ILLEGAL_FUNC_EN to flag function ids above 3 as illegal.
module sha256_sig_cfu
  import sha256_cfu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int FUNC_W = CFU_FUNC_W,
  parameter int ID_W   = CFU_ID_W
) (
  input logic         clk,
  input logic         rst_n,
  cfu_interface.slave cfu
);
  localparam int ENTRY_W = ID_W + 1 + 32;

  logic [31:0]        func_result;
  logic               func_status;
  logic [ENTRY_W-1:0] entry_in, entry_head;

  function automatic logic [31:0] ror32(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sig_calc(input cfu_func_e f, input logic [31:0] x);
    case (f)
      SIG0:    return ror32(x, 7)  ^ ror32(x, 18) ^ (x >> 3);
      SIG1:    return ror32(x, 17) ^ ror32(x, 19) ^ (x >> 10);
      SUM0:    return ror32(x, 2)  ^ ror32(x, 13) ^ ror32(x, 22);
      SUM1:    return ror32(x, 6)  ^ ror32(x, 11) ^ ror32(x, 25);
      default: return '0;
    endcase
  endfunction

  always_comb begin
    func_status = STATUS_OK;
    func_result = sig_calc(cfu_func_e'(cfu.req_func[1:0]), cfu.req_rs1);
`ifdef SHA256_SIG_CFU_ILLEGAL_FUNC_EN
    if (cfu.req_func > FUNC_W'(3)) begin
      func_status = STATUS_ILLEGAL;
      func_result = '0;
    end
`endif
  end

  assign entry_in = {cfu.req_id, func_status, func_result};

  // Result is captured on the transfer edge, so a response is visible one cycle later.
  cfu_resp_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_resp_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (cfu.req_valid),
    .push_ready (cfu.req_ready),
    .push_data  (entry_in),
    .pop_valid  (cfu.resp_valid),
    .pop_ready  (cfu.resp_ready),
    .pop_data   (entry_head)
  );

  assign {cfu.resp_id, cfu.resp_status, cfu.resp_data} = entry_head;

endmodule

// File: tb/tb_sha256_sig_cfu.sv
// Directed and randomized bench for sha256_sig_cfu against a queue-based reference model.
module tb_sha256_sig_cfu;
  localparam int DEPTH = 4;
  localparam int ID_W  = 4;

  typedef struct {
    logic [ID_W-1:0] id;
    logic [2:0]      func;
    logic [31:0]     rs1;
  } req_t;
  typedef logic [ID_W+32:0] ent_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  cfu_interface #(.ID_W(ID_W), .FUNC_W(3)) cfu_if ();

  sha256_sig_cfu #(.DEPTH(DEPTH), .FUNC_W(3), .ID_W(ID_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cfu   (cfu_if)
  );

  req_t pend[$];
  ent_t mq[$];
  ent_t log_q[$];
  int   log_cyc[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   next_id = 0;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    logic [31:0] v = x;
    for (int i = 0; i < n; i++) v = {v[0], v[31:1]};
    return v;
  endfunction

  function automatic logic [32:0] ref_fn(input logic [2:0] f, input logic [31:0] x);
`ifdef SHA256_SIG_CFU_ILLEGAL_FUNC_EN
    if (f > 3'd3) return {1'b1, 32'h0};
`endif
    case (f[1:0])
      2'd0:    return {1'b0, rotr(x, 7)  ^ rotr(x, 18) ^ (x >> 3)};
      2'd1:    return {1'b0, rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10)};
      2'd2:    return {1'b0, rotr(x, 2)  ^ rotr(x, 13) ^ rotr(x, 22)};
      default: return {1'b0, rotr(x, 6)  ^ rotr(x, 11) ^ rotr(x, 25)};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic add_req(input logic [2:0] f, input logic [31:0] x);
    req_t r;
    r.id   = ID_W'(next_id);
    r.func = f;
    r.rs1  = x;
    pend.push_back(r);
    next_id++;
  endtask

  task automatic apply(input int mode);
    cfu_if.req_valid = (pend.size() != 0);
    if (pend.size() != 0) begin
      cfu_if.req_id   = pend[0].id;
      cfu_if.req_func = pend[0].func;
      cfu_if.req_rs1  = pend[0].rs1;
    end else begin
      cfu_if.req_id   = ID_W'($urandom);
      cfu_if.req_func = 3'($urandom);
      cfu_if.req_rs1  = $urandom;
    end
    case (mode)
      0:       cfu_if.resp_ready = 1'b0;
      1:       cfu_if.resp_ready = 1'b1;
      2:       cfu_if.resp_ready = cyc[0];
      default: cfu_if.resp_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic tick();
    bit do_push, do_pop;
    #1;
    chk("req_ready", 64'(cfu_if.req_ready), 64'(mq.size() < DEPTH));
    chk("resp_valid", 64'(cfu_if.resp_valid), 64'(mq.size() != 0));
    if (mq.size() != 0)
      chk("resp_head", 64'({cfu_if.resp_id, cfu_if.resp_status, cfu_if.resp_data}), 64'(mq[0]));
    do_push = cfu_if.req_valid && (mq.size() < DEPTH);
    do_pop  = cfu_if.resp_ready && (mq.size() != 0);
    if (do_pop) begin
      log_q.push_back(mq.pop_front());
      log_cyc.push_back(cyc);
    end
    if (do_push) begin
      mq.push_back({cfu_if.req_id, ref_fn(cfu_if.req_func, cfu_if.req_rs1)});
      void'(pend.pop_front());
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_ticks(input int n, input int mode);
    repeat (n) begin
      apply(mode);
      tick();
    end
  endtask

  task automatic run_until_done(input int mode, input int budget);
    int k = 0;
    while ((pend.size() != 0 || mq.size() != 0) && k < budget) begin
      apply(mode);
      tick();
      k++;
    end
    checks++;
    assert (k < budget)
    else begin
      failures++;
      $error("FAIL drain_timeout observed=%0d cycles expected=below %0d", k, budget);
    end
    apply(mode);
  endtask

  task automatic start_group();
    next_id = 0;
    log_q.delete();
    log_cyc.delete();
  endtask

  task automatic check_ids(input string tag, input int n);
    ent_t e;
    chk({tag, "_count"}, 64'(log_q.size()), 64'(n));
    for (int i = 0; i < n && i < log_q.size(); i++) begin
      e = log_q[i];
      chk({tag, "_id"}, 64'(e[ID_W+32:33]), 64'(i % (1 << ID_W)));
    end
  endtask

  initial begin
    logic [31:0] kat [4];
    ent_t        e;
    kat[0] = 32'h0200_4000;
    kat[1] = 32'h0000_A000;
    kat[2] = 32'h4008_0400;
    kat[3] = 32'h0420_0080;

    cfu_if.req_valid  = 1'b0;
    cfu_if.req_id     = '0;
    cfu_if.req_func   = '0;
    cfu_if.req_rs1    = '0;
    cfu_if.resp_ready = 1'b0;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_resp_valid", 64'(cfu_if.resp_valid), 64'(0));
    chk("rst_req_ready", 64'(cfu_if.req_ready), 64'(1));
    chk("rst_resp_data", 64'(cfu_if.resp_data), 64'(0));
    chk("rst_resp_id", 64'(cfu_if.resp_id), 64'(0));
    chk("rst_resp_status", 64'(cfu_if.resp_status), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Known answers for rs1=1, one per cycle
    start_group();
    for (int f = 0; f < 4; f++) add_req(3'(f), 32'h1);
    run_until_done(1, 20);
    chk("kat_count", 64'(log_q.size()), 64'(4));
    for (int i = 0; i < 4 && i < log_q.size(); i++) begin
      e = log_q[i];
      chk("kat_data", 64'(e[31:0]), 64'(kat[i]));
      chk("kat_status", 64'(e[32]), 64'(0));
      chk("kat_spacing", 64'(log_cyc[i] - log_cyc[0]), 64'(i));
    end

    // Backpressure: fifth request held until responses drain
    start_group();
    for (int i = 0; i < 5; i++) add_req(3'($urandom_range(0, 3)), $urandom);
    run_ticks(5, 0);
    #1 chk("full_req_ready", 64'(cfu_if.req_ready), 64'(0));
    chk("full_resp_valid", 64'(cfu_if.resp_valid), 64'(1));
    run_until_done(1, 30);
    check_ids("bp", 5);

    // Full buffer with simultaneous request and pop
    start_group();
    for (int i = 0; i < 4; i++) add_req(3'($urandom_range(0, 3)), $urandom);
    run_ticks(4, 0);
    add_req(3'd2, $urandom);
    run_ticks(1, 1);
    run_ticks(1, 0);
    #1 chk("refill_req_ready", 64'(cfu_if.req_ready), 64'(0));
    run_until_done(1, 30);
    check_ids("full_pop", 5);

    // Pointer wrap with toggling resp_ready
    start_group();
    for (int i = 0; i < 10; i++) add_req(3'($urandom_range(0, 3)), $urandom);
    run_until_done(2, 100);
    check_ids("wrap", 10);

    // Reset with three responses buffered
    start_group();
    for (int i = 0; i < 3; i++) add_req(3'($urandom_range(0, 3)), $urandom);
    run_ticks(3, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_resp_valid", 64'(cfu_if.resp_valid), 64'(0));
    chk("midrst_req_ready", 64'(cfu_if.req_ready), 64'(1));
    chk("midrst_resp_data", 64'(cfu_if.resp_data), 64'(0));
    mq.delete();
    pend.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_ticks(4, 1);

    // Function id 5 handling
    start_group();
    add_req(3'd5, 32'h1);
    run_until_done(1, 10);
    chk("f5_count", 64'(log_q.size()), 64'(1));
    if (log_q.size() != 0) begin
      e = log_q[0];
`ifdef SHA256_SIG_CFU_ILLEGAL_FUNC_EN
      chk("f5_data", 64'(e[31:0]), 64'(0));
      chk("f5_status", 64'(e[32]), 64'(1));
`else
      chk("f5_data", 64'(e[31:0]), 64'(32'h0000_A000));
      chk("f5_status", 64'(e[32]), 64'(0));
`endif
    end

    // Randomized traffic with random backpressure and all function ids
    start_group();
    for (int i = 0; i < 40; i++) add_req(3'($urandom_range(0, 7)), $urandom);
    run_until_done(3, 600);
    check_ids("rand", 40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
